// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch controller that closes the loop around the PC register.
//   It fetches the word at pcAtual over a level req / single-cycle ack
//   handshake, holds it in a register for the downstream consumer, and
//   computes the next PC every cycle (hold, sequential advance or branch
//   redirect). A HALT opcode raises isHalt for one cycle so the PC register
//   freezes and sets its sticky halted flag.
//
// Ports
//   clock, resetCPU          : rising-edge clock, asynchronous active-high reset
//   pcAtual, halted          : current PC and sticky halt flag from PC register
//   branchTaken/branchTarget : one-cycle redirect request from execute
//   stall                    : downstream cannot consume instr this cycle
//   imem_req/imem_addr       : instruction read request (level) and address
//   imem_ack/imem_rdata      : read completion strobe and returned word
//   instr/instrValid         : registered instruction and its valid flag
//   pcNext                   : next PC to the PC register (combinational)
//   isHalt                   : halt request to the PC register (combinational)
module fetch_unit #(
  parameter logic [5:0]  HALT_OPCODE = 6'b111111,
  parameter logic [31:0] PC_STEP     = 32'd1
) (
  input  logic        clock,
  input  logic        resetCPU,
  input  logic [31:0] pcAtual,
  input  logic        halted,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instrValid,
  output logic [31:0] pcNext,
  output logic        isHalt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DELIVER = 2'd2,
    S_STOP    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;

  logic is_halt_op;
  logic deliver_go;
  logic do_advance;
  logic do_halt;
  logic load_instr;

  assign is_halt_op = (instr_q[31:26] == HALT_OPCODE);

  // The held instruction is consumed only when downstream is ready and
  // neither a redirect nor an external halt overrides it this cycle.
  assign deliver_go = (state_q == S_DELIVER) && !stall && !branchTaken && !halted;
  assign do_advance = deliver_go && !is_halt_op;
  assign do_halt    = deliver_go && is_halt_op;

  // An ack that coincides with a redirect belongs to the old PC and is dropped.
  assign load_instr = (state_q == S_FETCH) && imem_ack && !branchTaken && !halted;

  // State register
  always_ff @(posedge clock or posedge resetCPU) begin
    if (resetCPU) begin
      state_q <= S_IDLE;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    instr_d = load_instr ? imem_rdata : instr_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = halted ? S_STOP : S_FETCH;
      end
      S_FETCH: begin
        if (halted)           state_d = S_STOP;
        else if (branchTaken) state_d = S_FETCH;
        else if (imem_ack)    state_d = S_DELIVER;
      end
      S_DELIVER: begin
        // A redirect flushes the held word even while stalled or if it is HALT.
        if (halted)           state_d = S_STOP;
        else if (branchTaken) state_d = S_FETCH;
        else if (!stall)      state_d = is_halt_op ? S_STOP : S_FETCH;
      end
      S_STOP: begin
        state_d = S_STOP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    imem_req   = (state_q == S_FETCH);
    instrValid = (state_q == S_DELIVER);
    isHalt     = do_halt;
    if ((state_q == S_STOP) || halted) begin
      pcNext = pcAtual;
    end else if (branchTaken) begin
      pcNext = branchTarget;
    end else if (do_advance) begin
      pcNext = pcAtual + PC_STEP;
    end else begin
      pcNext = pcAtual;
    end
  end

  assign imem_addr = pcAtual;
  assign instr     = instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        resetCPU = 1'b1;
  logic        branchTaken = 1'b0;
  logic [31:0] branchTarget = 32'd0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instrValid;
  logic [31:0] pcNext;
  logic        isHalt;

  // Environment: PC register and instruction memory
  logic [31:0] pc_q;
  logic        halted_q;
  logic        pc_force_en = 1'b0;
  logic [31:0] pc_force_val = 32'd0;
  logic [31:0] mem [0:255];
  int          mem_wait = 0;
  int          mem_cnt;

  int checks = 0;
  int errors = 0;
  int halt_pulses = 0;

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock        (clock),
    .resetCPU     (resetCPU),
    .pcAtual      (pc_q),
    .halted       (halted_q),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instrValid   (instrValid),
    .pcNext       (pcNext),
    .isHalt       (isHalt)
  );

  assign imem_ack   = imem_req && (mem_cnt >= mem_wait);
  assign imem_rdata = mem[imem_addr[7:0]];

  always @(posedge clock or posedge resetCPU) begin
    if (resetCPU)                 mem_cnt <= 0;
    else if (!imem_req || imem_ack) mem_cnt <= 0;
    else                          mem_cnt <= mem_cnt + 1;
  end

  always @(posedge clock or posedge resetCPU) begin
    if (resetCPU) begin
      pc_q     <= 32'd0;
      halted_q <= 1'b0;
    end else begin
      pc_q <= pc_force_en ? pc_force_val : pcNext;
      if (isHalt) halted_q <= 1'b1;
    end
  end

  // Behavioural model: started / holding-a-word / stopped flags
  logic        m_on = 1'b0;
  logic        m_have = 1'b0;
  logic        m_stop = 1'b0;
  logic [31:0] m_instr = 32'd0;

  always @(posedge clock or posedge resetCPU) begin
    if (resetCPU) begin
      m_on    <= 1'b0;
      m_have  <= 1'b0;
      m_stop  <= 1'b0;
      m_instr <= 32'd0;
    end else if (!m_stop) begin
      if (halted_q) begin
        m_stop <= 1'b1;
        m_have <= 1'b0;
      end else if (!m_on) begin
        m_on <= 1'b1;
      end else if (!m_have) begin
        if (!branchTaken && (mem_cnt >= mem_wait)) begin
          m_have  <= 1'b1;
          m_instr <= mem[pc_q[7:0]];
        end
      end else if (branchTaken) begin
        m_have <= 1'b0;
      end else if (!stall) begin
        if (m_instr[31:26] == 6'h3F) m_stop <= 1'b1;
        m_have <= 1'b0;
      end
    end
  end

  logic        e_req, e_valid, e_go, e_halt;
  logic [31:0] e_pcnext;

  always_comb begin
    e_valid = m_have && !m_stop;
    e_req   = m_on && !m_stop && !m_have;
    e_go    = e_valid && !halted_q && !branchTaken && !stall;
    e_halt  = e_go && (m_instr[31:26] == 6'h3F);
    if (m_stop || halted_q)   e_pcnext = pc_q;
    else if (branchTaken)     e_pcnext = branchTarget;
    else if (e_go && !e_halt) e_pcnext = 32'((64'(pc_q) + 64'd1) % 64'h1_0000_0000);
    else                      e_pcnext = pc_q;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clock);
      chk1("m_imem_req", imem_req, e_req);
      chk1("m_instrValid", instrValid, e_valid);
      chk1("m_isHalt", isHalt, e_halt);
      chk("m_pcNext", pcNext, e_pcnext);
      chk("m_imem_addr", imem_addr, pc_q);
      chk("m_instr", instr, m_instr);
      if (isHalt) halt_pulses++;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  // Leaves the caller just after the edge that starts cycle 0.
  task automatic do_reset();
    @(posedge clock);
    #1;
    resetCPU    = 1'b1;
    branchTaken = 1'b0;
    stall       = 1'b0;
    mem_wait    = 0;
    pc_force_en = 1'b0;
    @(posedge clock);
    #1;
    resetCPU    = 1'b0;
    halt_pulses = 0;
  endtask

  logic [31:0] t1_pc [8];
  logic        t1_v  [8];
  logic [31:0] t1_w  [3];

  initial begin
    t1_pc = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd3};
    t1_v  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    t1_w  = '{32'h11111111, 32'h22222222, 32'h33333333};
    clear_mem();
    mem[0] = 32'h11111111;
    mem[1] = 32'h22222222;
    mem[2] = 32'h33333333;

    // Reset state
    @(negedge clock);
    chk("rst_instr", instr, 32'd0);
    chk1("rst_valid", instrValid, 1'b0);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_isHalt", isHalt, 1'b0);
    chk("rst_pcNext", pcNext, 32'd0);
    @(posedge clock);
    #1 resetCPU = 1'b0;

    // Straight-line fetch, zero wait
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      chk("t1_pc", pc_q, t1_pc[c]);
      chk1("t1_valid", instrValid, t1_v[c]);
      if (t1_v[c]) chk("t1_instr", instr, t1_w[c / 2 - 1]);
    end

    // Wait states and stall
    do_reset();
    clear_mem();
    mem[0] = 32'hA0000001;
    mem_wait = 3;
    repeat (5) @(negedge clock);
    chk1("t2_req_c4", imem_req, 1'b1);
    chk1("t2_ack_c4", imem_ack, 1'b1);
    @(posedge clock);
    #1 stall = 1'b1;
    @(negedge clock);
    chk1("t2_valid_c5", instrValid, 1'b1);
    chk("t2_pcNext_c5", pcNext, 32'd0);
    chk("t2_instr_c5", instr, 32'hA0000001);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("t2_pcNext_c6", pcNext, 32'd0);
    chk("t2_instr_c6", instr, 32'hA0000001);
    @(posedge clock);
    #1 stall = 1'b0;
    mem_wait = 0;
    @(negedge clock);
    chk("t2_pcNext_c7", pcNext, 32'd1);

    // HALT
    do_reset();
    clear_mem();
    mem[0] = 32'h11111111;
    mem[1] = 32'h22222222;
    mem[2] = 32'hFC000000;
    repeat (7) @(negedge clock);
    chk1("t3_isHalt_c6", isHalt, 1'b1);
    chk("t3_pcNext_c6", pcNext, 32'd2);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk1("t3_isHalt_c7", isHalt, 1'b0);
    chk1("t3_halted_c7", halted_q, 1'b1);
    chk1("t3_req_c7", imem_req, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1 branchTaken = 1'b1;
      branchTarget = 32'h80;
      @(posedge clock);
      #1 branchTaken = 1'b0;
    end
    repeat (3) @(negedge clock);
    chk("t3_pc_frozen", pc_q, 32'd2);
    chk1("t3_req_off", imem_req, 1'b0);
    chk("t3_halt_pulses", 32'(halt_pulses), 32'd1);

    // Branch in FETCH with same-cycle ack
    do_reset();
    clear_mem();
    mem[0]    = 32'hAAAA0000;
    mem[8'h40] = 32'h12345678;
    @(posedge clock);
    #1 branchTaken = 1'b1;
    branchTarget = 32'h40;
    @(negedge clock);
    chk1("t4_ack_c1", imem_ack, 1'b1);
    chk("t4_pcNext_c1", pcNext, 32'h40);
    @(posedge clock);
    #1 branchTaken = 1'b0;
    @(negedge clock);
    chk("t4_addr_c2", imem_addr, 32'h40);
    chk1("t4_req_c2", imem_req, 1'b1);
    chk1("t4_valid_c2", instrValid, 1'b0);
    chk("t4_instr_c2", instr, 32'd0);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("t4_instr_c3", instr, 32'h12345678);
    chk("t4_pcNext_c3", pcNext, 32'h41);

    // Branch flushes held HALT while stalled
    do_reset();
    clear_mem();
    mem[0]     = 32'hFC000000;
    mem[8'h20] = 32'h01020304;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1 stall = 1'b1;
    @(negedge clock);
    chk1("t5_valid_c2", instrValid, 1'b1);
    chk1("t5_isHalt_c2", isHalt, 1'b0);
    @(posedge clock);
    #1 branchTaken = 1'b1;
    branchTarget = 32'h20;
    @(negedge clock);
    chk1("t5_isHalt_c3", isHalt, 1'b0);
    chk("t5_pcNext_c3", pcNext, 32'h20);
    @(posedge clock);
    #1 branchTaken = 1'b0;
    stall = 1'b0;
    @(negedge clock);
    chk1("t5_valid_c4", instrValid, 1'b0);
    chk1("t5_req_c4", imem_req, 1'b1);
    chk("t5_pc_c4", pc_q, 32'h20);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("t5_instr_c5", instr, 32'h01020304);
    repeat (2) @(negedge clock);
    chk("t5_halt_pulses", 32'(halt_pulses), 32'd0);

    // PC wrap, then reset in the middle of a fetch
    do_reset();
    clear_mem();
    mem[8'hFF] = 32'h0000ABCD;
    pc_force_val = 32'hFFFFFFFF;
    pc_force_en  = 1'b1;
    @(posedge clock);
    #1 pc_force_en = 1'b0;
    @(negedge clock);
    chk("t6_addr_c1", imem_addr, 32'hFFFFFFFF);
    @(posedge clock);
    #1 mem_wait = 5;
    @(negedge clock);
    chk("t6_instr_c2", instr, 32'h0000ABCD);
    chk("t6_pcNext_wrap", pcNext, 32'd0);
    @(posedge clock);
    #1;
    chk1("t6_req_before", imem_req, 1'b1);
    #2 resetCPU = 1'b1;
    #1;
    chk1("t6_req_async", imem_req, 1'b0);
    chk1("t6_valid_rst", instrValid, 1'b0);
    chk("t6_instr_rst", instr, 32'd0);
    chk1("t6_isHalt_rst", isHalt, 1'b0);
    chk("t6_pcNext_rst", pcNext, 32'd0);
    @(posedge clock);
    #1 resetCPU = 1'b0;
    mem_wait = 0;
    repeat (4) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
